// File: rtl/seq_game_pkg.sv
// Shared definitions for the sequence-game controller.
// Contents:
//   state_e      - controller state encoding (3 bits)
//   MAX_LEN_DEF  - default final level (ROM depth)
//   ROM_AW       - sequence ROM address width
//   LED_W        - LED / button / ROM data width
//   LVL_W        - width of the level output (holds 0..16)
//   max3()       - helper used to size the shared step timer
package seq_game_pkg;

    localparam int MAX_LEN_DEF = 16;
    localparam int ROM_AW      = 4;
    localparam int LED_W       = 4;
    localparam int LVL_W       = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHOW_ON  = 3'd1,
        SHOW_OFF = 3'd2,
        WAIT_IN  = 3'd3,
        WIN      = 3'd4,
        LOSE     = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/seq_step_timer.sv
// Loadable down-counter shared by the show, gap and input-timeout phases.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (count clears to 0)
//   load      - load load_val this cycle (has priority over en)
//   load_val  - value to load; a phase of N cycles loads N-1
//   en        - decrement by one; the count saturates at zero
//   done      - count is zero
module seq_step_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/seq_game_ctrl.sv
// Sequencing controller for a 16-entry one-hot sequence ROM game.
// Plays back the first L ROM entries on the LEDs, then checks the player's
// presses against the same entries; L grows by one per correct round up to
// MAX_LEN.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - pulse; starts a new game from IDLE, WIN or LOSE
//   btn       - debounced single-cycle press pulses (0 = no press)
//   rom_data  - combinational ROM output for rom_addr
//   rom_addr  - registered ROM address
//   leds      - ROM data while a step is lit, otherwise 0
//   level     - current sequence length, 0 in IDLE
//   busy      - showing the sequence or waiting for input
//   win, lose - game outcome, held until start or rst
module seq_game_ctrl
    import seq_game_pkg::*;
#(
    parameter int SHOW_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 20,
    parameter int MAX_LEN        = MAX_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LED_W-1:0]  btn,
    input  logic [LED_W-1:0]  rom_data,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [LED_W-1:0]  leds,
    output logic [LVL_W-1:0]  level,
    output logic              busy,
    output logic              win,
    output logic              lose
);

    localparam int TMR_MAX = max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
    // N bits hold values up to 2**N-1; the largest load is TMR_MAX-1.
    localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

    localparam logic [TMR_W-1:0] LD_SHOW = TMR_W'(SHOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] LD_GAP  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] LD_TMO  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEN);

    state_e             state_q, state_d;
    logic [LVL_W-1:0]   level_q, level_d;
    // The step index doubles as the ROM address: both start at 0 and
    // advance together, so one register serves both.
    logic [ROM_AW-1:0]  idx_q, idx_d;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_en;
    logic               tmr_done;
    logic               is_last;

    seq_step_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    // idx never exceeds level-1, so equality marks the final step.
    assign is_last = ({1'b0, idx_q} == (level_q - LVL_W'(1)));

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;
        tmr_val  = LD_SHOW;
        tmr_en   = 1'b0;

        case (state_q)
            IDLE, WIN, LOSE: begin
                if (start) begin
                    state_d  = SHOW_ON;
                    level_d  = LVL_W'(1);
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SHOW;
                end
            end

            SHOW_ON: begin
                if (tmr_done) begin
                    state_d  = SHOW_OFF;
                    tmr_load = 1'b1;
                    tmr_val  = LD_GAP;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            SHOW_OFF: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (!is_last) begin
                        state_d = SHOW_ON;
                        idx_d   = idx_q + ROM_AW'(1);
                        tmr_val = LD_SHOW;
                    end else begin
                        state_d = WAIT_IN;
                        idx_d   = '0;
                        tmr_val = LD_TMO;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end

            WAIT_IN: begin
                // A press always wins over a timeout on the same cycle.
                if (btn != '0) begin
                    if (btn == rom_data) begin
                        tmr_load = 1'b1;
                        tmr_val  = LD_TMO;
                        if (!is_last) begin
                            idx_d = idx_q + ROM_AW'(1);
                        end else if (level_q == LVL_MAX) begin
                            state_d = WIN;
                        end else begin
                            state_d = SHOW_ON;
                            level_d = level_q + LVL_W'(1);
                            idx_d   = '0;
                            tmr_val = LD_SHOW;
                        end
                    end else begin
                        state_d = LOSE;
                    end
                end else if (tmr_done) begin
                    state_d = LOSE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            level_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
        end
    end

    assign rom_addr = idx_q;
    assign level    = level_q;
    assign leds     = (state_q == SHOW_ON) ? rom_data : '0;
    assign busy     = (state_q == SHOW_ON) || (state_q == SHOW_OFF) || (state_q == WAIT_IN);
    assign win      = (state_q == WIN);
    assign lose     = (state_q == LOSE);

endmodule

// File: tb/tb_seq_game_ctrl.sv
// Bench for seq_game_ctrl: a phase/elapsed-time model of the game rules
// checked against the DUT on every clock, plus directed literal checks.
module tb_seq_game_ctrl;

    localparam int SHOW = 4;
    localparam int GAP  = 2;
    localparam int TMO  = 20;
    localparam int MAXL = 16;

    localparam int P_IDLE = 0;
    localparam int P_ON   = 1;
    localparam int P_OFF  = 2;
    localparam int P_WAIT = 3;
    localparam int P_WIN  = 4;
    localparam int P_LOSE = 5;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn   = 4'b0000;
    logic [3:0] rom_data;
    logic [3:0] rom_addr;
    logic [3:0] leds;
    logic [4:0] level;
    logic       busy;
    logic       win;
    logic       lose;

    logic [3:0] rom [0:15] = '{4'b0001, 4'b0100, 4'b0001, 4'b1000,
                               4'b0010, 4'b0010, 4'b0100, 4'b0001,
                               4'b1000, 4'b0100, 4'b0010, 4'b0001,
                               4'b0001, 4'b1000, 4'b0100, 4'b0010};

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    seq_game_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .btn      (btn),
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .leds     (leds),
        .level    (level),
        .busy     (busy),
        .win      (win),
        .lose     (lose)
    );

    // Game model: phase, cycles spent in the current phase/window, level, step.
    int m_phase = P_IDLE;
    int m_t     = 0;
    int m_level = 0;
    int m_idx   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= P_IDLE;
            m_t     <= 0;
            m_level <= 0;
            m_idx   <= 0;
        end else begin
            case (m_phase)
                P_IDLE, P_WIN, P_LOSE: begin
                    if (start) begin
                        m_phase <= P_ON;
                        m_level <= 1;
                        m_idx   <= 0;
                        m_t     <= 0;
                    end
                end
                P_ON: begin
                    if (m_t + 1 == SHOW) begin
                        m_phase <= P_OFF;
                        m_t     <= 0;
                    end else begin
                        m_t <= m_t + 1;
                    end
                end
                P_OFF: begin
                    if (m_t + 1 == GAP) begin
                        m_t <= 0;
                        if (m_idx + 1 < m_level) begin
                            m_idx   <= m_idx + 1;
                            m_phase <= P_ON;
                        end else begin
                            m_idx   <= 0;
                            m_phase <= P_WAIT;
                        end
                    end else begin
                        m_t <= m_t + 1;
                    end
                end
                P_WAIT: begin
                    if (btn != 4'b0000) begin
                        if (btn == rom[m_idx]) begin
                            m_t <= 0;
                            if (m_idx + 1 < m_level) begin
                                m_idx <= m_idx + 1;
                            end else if (m_level == MAXL) begin
                                m_phase <= P_WIN;
                            end else begin
                                m_level <= m_level + 1;
                                m_idx   <= 0;
                                m_phase <= P_ON;
                            end
                        end else begin
                            m_phase <= P_LOSE;
                        end
                    end else if (m_t + 1 == TMO) begin
                        m_phase <= P_LOSE;
                    end else begin
                        m_t <= m_t + 1;
                    end
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp_model();
        int exp_leds;
        exp_leds = (m_phase == P_ON) ? int'(rom[m_idx]) : 0;
        chk("m_leds",  int'(leds),     exp_leds);
        chk("m_addr",  int'(rom_addr), m_idx);
        chk("m_level", int'(level),    m_level);
        chk("m_busy",  int'(busy),     (m_phase == P_ON || m_phase == P_OFF || m_phase == P_WAIT) ? 1 : 0);
        chk("m_win",   int'(win),      (m_phase == P_WIN) ? 1 : 0);
        chk("m_lose",  int'(lose),     (m_phase == P_LOSE) ? 1 : 0);
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_for_wait();
        int n;
        n = 0;
        while (m_phase != P_WAIT && n < 300) begin
            tick();
            n++;
        end
        if (m_phase != P_WAIT) begin
            checks++;
            errors++;
            $display("FAIL wait_in_timeout got_phase=%0d want=%0d", m_phase, P_WAIT);
        end
    endtask

    task automatic play_round();
        int n;
        n = m_level;
        for (int i = 0; i < n; i++) begin
            btn = rom[i];
            tick();
            btn = 4'b0000;
            tick();
        end
    endtask

    int exp2 [0:11] = '{1, 1, 1, 1, 0, 0, 4, 4, 4, 4, 0, 0};

    initial begin
        int guard;

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_leds",  int'(leds),     0);
        chk("rst_level", int'(level),    0);
        chk("rst_addr",  int'(rom_addr), 0);
        chk("rst_busy",  int'(busy),     0);
        chk("rst_win",   int'(win),      0);
        chk("rst_lose",  int'(lose),     0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();

        // Level 1 playback
        pulse_start();
        chk("l1_level", int'(level),    1);
        chk("l1_addr",  int'(rom_addr), 0);
        for (int i = 0; i < 6; i++) begin
            chk("l1_leds", int'(leds), (i < 4) ? 1 : 0);
            chk("l1_busy", int'(busy), 1);
            tick();
        end
        chk("l1_wait_busy", int'(busy), 1);
        chk("l1_wait_leds", int'(leds), 0);

        // Correct press, level 2 playback
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        chk("l2_level", int'(level), 2);
        for (int i = 0; i < 12; i++) begin
            chk("l2_leds", int'(leds), exp2[i]);
            tick();
        end
        chk("l2_wait_busy", int'(busy), 1);

        // Level 2 correct, then level 3 with a wrong second press
        play_round();
        wait_for_wait();
        chk("l3_level", int'(level), 3);
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        tick();
        btn = 4'b0010;
        tick();
        btn = 4'b0000;
        chk("l3_lose",  int'(lose),  1);
        chk("l3_busy",  int'(busy),  0);
        chk("l3_level", int'(level), 3);
        for (int k = 0; k < 4; k++) begin
            btn = rom[k];
            tick();
            btn = 4'b0000;
            tick();
        end
        chk("lose_hold",       int'(lose),  1);
        chk("lose_hold_level", int'(level), 3);

        // Timeout with no press
        pulse_start();
        chk("tmo_restart_lose", int'(lose), 0);
        wait_for_wait();
        repeat (19) tick();
        chk("tmo_c20_lose", int'(lose), 0);
        chk("tmo_c20_busy", int'(busy), 1);
        tick();
        chk("tmo_lose",  int'(lose),  1);
        chk("tmo_busy",  int'(busy),  0);
        chk("tmo_level", int'(level), 1);

        // Correct press on the last cycle of the window is accepted
        pulse_start();
        wait_for_wait();
        repeat (19) tick();
        btn = rom[0];
        tick();
        btn = 4'b0000;
        chk("late_press_lose",  int'(lose),  0);
        chk("late_press_level", int'(level), 2);
        chk("late_press_busy",  int'(busy),  1);

        // Full play to MAX_LEN
        guard = 0;
        while (m_phase != P_WIN && guard < 20) begin
            wait_for_wait();
            play_round();
            guard++;
        end
        chk("win_flag",  int'(win),   1);
        chk("win_level", int'(level), 16);
        chk("win_busy",  int'(busy),  0);
        pulse_start();
        chk("restart_win",   int'(win),   0);
        chk("restart_level", int'(level), 1);

        // Async reset during SHOW_ON at level 5
        guard = 0;
        while (m_level < 5 && guard < 10) begin
            wait_for_wait();
            play_round();
            guard++;
        end
        chk("l5_level", int'(level), 5);
        chk("l5_leds",  int'(leds),  int'(rom[0]));
        #2 rst = 1'b1;
        #1;
        chk("arst_leds",  int'(leds),     0);
        chk("arst_level", int'(level),    0);
        chk("arst_addr",  int'(rom_addr), 0);
        chk("arst_busy",  int'(busy),     0);
        chk("arst_win",   int'(win),      0);
        chk("arst_lose",  int'(lose),     0);
        tick();
        rst = 1'b0;
        tick();
        pulse_start();
        chk("post_rst_level", int'(level),    1);
        chk("post_rst_addr",  int'(rom_addr), 0);
        chk("post_rst_busy",  int'(busy),     1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
